// File: rtl/lsu_ctrl.sv
// Load/store sequencer for the MEM phase: legality check, word-port handshake
// with byte lanes, and lane-shifted sign/zero extension of load data.
module lsu_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;

    function automatic logic f3_illegal(input logic st, input logic [2:0] f3);
        if (st) return f3 > 3'd2;
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Faults skip the memory port entirely and report next cycle.
                    if (f3_illegal(we, funct3)) begin
                        err_d   = 2'b11;
                        state_d = DONE;
                    end else if (misaligned(funct3, addr[1:0])) begin
                        err_d   = 2'b01;
                        state_d = DONE;
                    end else begin
                        we_d     = we;
                        funct3_d = funct3;
                        addr_d   = addr;
                        wdata_d  = wdata;
                        cnt_d    = 8'd0;
                        err_d    = 2'b00;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final wait cycle still counts as success.
                if (mem_ack) begin
                    err_d   = 2'b00;
                    state_d = DONE;
                    if (!we_q) rdata_d = load_ext(funct3_q, addr_q[1:0], mem_rdata);
                end else if (cnt_q == LAST_CNT) begin
                    err_d   = 2'b10;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = mem_req ? lane_be(funct3_q, addr_q[1:0]) : 4'b0000;
    assign mem_wdata = mem_we ? store_data(funct3_q, wdata_q) : 32'd0;

endmodule
